// File: rtl/spi_master_arb.sv
// spi_master_arb: round-robin arbitrated SPI mode-0 master,
// one 8-bit full-duplex transfer per grant.
module spi_master_arb #(
   parameter int NREQ   = 2,
   parameter int NSS    = 4,
   parameter int SLVW   = 2,
   parameter int CLKDIV = 4,
   parameter int GAP    = 4
) (
   input  logic                 Clk_i,
   input  logic                 Rst_ni,
   input  logic [NREQ-1:0]      Req_i,
   input  logic [NREQ*SLVW-1:0] Slv_i,
   input  logic [NREQ*8-1:0]    Data_i,
   output logic [NREQ-1:0]      Gnt_o,
   output logic [NREQ-1:0]      Done_o,
   output logic [7:0]           Rdata_o,
   output logic                 Busy_o,
   output logic                 sck_o,
   output logic                 mosi_o,
   input  logic                 miso_i,
   output logic [NSS-1:0]       ss_o
);
   localparam int MAXC = (CLKDIV > GAP) ? CLKDIV : GAP;
   localparam int CNTW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int LW   = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [CNTW-1:0] DIVLD   = CNTW'(CLKDIV - 1);
   localparam logic [CNTW-1:0] GAPLD   = CNTW'(GAP - 1);
   localparam logic [LW-1:0]   LASTRST = LW'(NREQ - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_HOLD,
      S_GAP
   } state_t;

   state_t          r_state;
   logic [CNTW-1:0] r_cnt;
   logic [2:0]      r_bit;
   logic [7:0]      r_tx;
   logic [7:0]      r_rx;
   logic [7:0]      r_rdata;
   logic [LW-1:0]   r_last;
   logic [NSS-1:0]  r_ss;
   logic [NREQ-1:0] r_gnt;
   logic [NREQ-1:0] r_done;
   logic            r_busy;
   logic            r_sck;

   logic            w_found;
   logic [LW-1:0]   w_win;
   int              w_idx;
   logic [SLVW-1:0] w_slv;
   logic [7:0]      w_data;
   logic [NSS-1:0]  w_ss;
   logic [NREQ-1:0] w_gnt1h;
   logic [NREQ-1:0] w_last1h;

   // Scan starts just after the previous winner so every
   // requester is served within NREQ transfers.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = 0;
      for (int i = 1; i <= NREQ; i++) begin
         w_idx = (int'(r_last) + i) % NREQ;
         if (!w_found && Req_i[w_idx]) begin
            w_found = 1'b1;
            w_win   = LW'(w_idx);
         end
      end
   end

   assign w_slv  = Slv_i[int'(w_win)*SLVW +: SLVW];
   assign w_data = Data_i[int'(w_win)*8 +: 8];

   // Out-of-range indices decode to no select at all.
   always_comb begin
      w_ss = '0;
      for (int j = 0; j < NSS; j++) begin
         w_ss[j] = (int'(w_slv) == j);
      end
   end

   always_comb begin
      w_gnt1h  = '0;
      w_last1h = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_gnt1h[k]  = (int'(w_win) == k);
         w_last1h[k] = (int'(r_last) == k);
      end
   end

   always_ff @(posedge Clk_i or negedge Rst_ni) begin
      if (!Rst_ni) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_rdata <= '0;
         r_last  <= LASTRST;
         r_ss    <= '0;
         r_gnt   <= '0;
         r_done  <= '0;
         r_busy  <= 1'b0;
         r_sck   <= 1'b0;
      end else begin
         r_gnt  <= '0;
         r_done <= '0;
         unique case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_tx    <= w_data;
                  r_ss    <= w_ss;
                  r_last  <= w_win;
                  r_gnt   <= w_gnt1h;
                  r_cnt   <= DIVLD;
                  r_bit   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_cnt == '0) begin
                  r_sck   <= 1'b1;
                  r_rx    <= {r_rx[6:0], miso_i};
                  r_cnt   <= DIVLD;
                  r_state <= S_HIGH;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_HIGH: begin
               if (r_cnt == '0) begin
                  r_sck <= 1'b0;
                  r_cnt <= DIVLD;
                  if (r_bit == 3'd7) begin
                     r_state <= S_HOLD;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_tx    <= {r_tx[6:0], 1'b0};
                     r_state <= S_LOW;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_LOW: begin
               if (r_cnt == '0) begin
                  r_sck   <= 1'b1;
                  r_rx    <= {r_rx[6:0], miso_i};
                  r_cnt   <= DIVLD;
                  r_state <= S_HIGH;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_HOLD: begin
               // Keeps ss and mosi up so the slave syncs the last edge.
               if (r_cnt == '0) begin
                  r_rdata <= r_rx;
                  r_ss    <= '0;
                  r_done  <= w_last1h;
                  r_cnt   <= GAPLD;
                  r_state <= S_GAP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_GAP: begin
               if (r_cnt == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Gnt_o   = r_gnt;
   assign Done_o  = r_done;
   assign Rdata_o = r_rdata;
   assign Busy_o  = r_busy;
   assign sck_o   = r_sck;
   assign mosi_o  = r_tx[7];
   assign ss_o    = r_ss;

endmodule

// File: tb/tb_spi_master_arb.sv
// tb_spi_master_arb: directed transfers against a cycle-indexed
// timeline model of the SPI master, compared every cycle.
`timescale 1ns/1ps
module tb_spi_master_arb;
   localparam int NREQ   = 2;
   localparam int NSS    = 3;
   localparam int SLVW   = 2;
   localparam int CLKDIV = 4;
   localparam int GAP    = 4;
   localparam int TDONE  = 17*CLKDIV + 1;
   localparam int TEND   = 17*CLKDIV + GAP;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*SLVW-1:0] slv = '0;
   logic [NREQ*8-1:0]    data = '0;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      done;
   logic [7:0]           rdata;
   logic                 busy;
   logic                 sck;
   logic                 mosi;
   logic                 miso;
   logic                 miso_r = 1'b0;
   logic [NSS-1:0]       ss;

   int         mode = 0;
   logic [7:0] sl_byte = 8'h3C;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;

   assign miso = (mode == 1) ? mosi : miso_r;

   always #5 clk = ~clk;

   spi_master_arb #(
      .NREQ(NREQ), .NSS(NSS), .SLVW(SLVW),
      .CLKDIV(CLKDIV), .GAP(GAP)
   ) dut (
      .Clk_i(clk),
      .Rst_ni(rst_n),
      .Req_i(req),
      .Slv_i(slv),
      .Data_i(data),
      .Gnt_o(gnt),
      .Done_o(done),
      .Rdata_o(rdata),
      .Busy_o(busy),
      .sck_o(sck),
      .mosi_o(mosi),
      .miso_i(miso),
      .ss_o(ss)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h",
                  nm, cyc, act, exp);
      end
   endtask

   // Slave: presents the next bit after every falling sck edge.
   int   nf = 0;
   logic sck_q = 1'b0;
   always @(negedge clk) begin
      if (!busy) nf = 0;
      else if (sck_q && !sck) nf = nf + 1;
      sck_q = sck;
      if (mode == 2 || nf > 7) miso_r = 1'b0;
      else miso_r = sl_byte[7-nf];
   end

   logic       m_act = 1'b0;
   int         m_t0 = 0;
   int         m_win = 0;
   int         m_slv = 0;
   int         m_last = NREQ-1;
   logic [7:0] m_data = '0;
   logic [7:0] m_rx = '0;
   logic [7:0] m_rdata = '0;
   logic       m_mosi_idle = 1'b0;

   int         g_cyc[$];
   int         g_id[$];
   int         d_cyc[$];
   int         d_id[$];
   logic [7:0] d_rd[$];
   logic [7:0] mosi_bits = '0;
   int         n_rise = 0;
   int         ss_hits = 0;
   logic [NSS-1:0] ss_or = '0;
   logic       sck_c = 1'b0;

   always @(negedge clk) begin
      logic [NREQ-1:0] e_gnt;
      logic [NREQ-1:0] e_done;
      logic [NSS-1:0]  e_ss;
      logic            e_sck;
      logic            e_mosi;
      logic            e_busy;
      logic            fnd;
      int              d;
      int              p;
      int              sh;
      e_gnt  = '0;
      e_done = '0;
      e_ss   = '0;
      e_sck  = 1'b0;
      e_mosi = 1'b0;
      e_busy = 1'b0;
      if (!rst_n) begin
         m_act       = 1'b0;
         m_last      = NREQ-1;
         m_rdata     = '0;
         m_mosi_idle = 1'b0;
      end else begin
         if (m_act && (cyc - m_t0) > TEND) begin
            m_act       = 1'b0;
            m_mosi_idle = m_data[0];
         end
         if (m_act) begin
            d = cyc - m_t0;
            e_busy = 1'b1;
            if (d == 1) e_gnt[m_win] = 1'b1;
            if (d == TDONE) begin
               e_done[m_win] = 1'b1;
               m_rdata = m_rx;
            end
            if (d <= 17*CLKDIV) begin
               p = (d - 1) / CLKDIV;
               e_sck = (p % 2 == 1) && (p <= 15);
               sh = (p / 2 > 7) ? 7 : p / 2;
               e_mosi = m_data[7-sh];
               if (m_slv < NSS) e_ss[m_slv] = 1'b1;
            end else begin
               e_mosi = m_data[0];
            end
         end else begin
            e_mosi = m_mosi_idle;
         end
      end
      chk("gnt", gnt, e_gnt);
      chk("done", done, e_done);
      chk("rdata", rdata, m_rdata);
      chk("busy", busy, e_busy);
      chk("sck", sck, e_sck);
      chk("mosi", mosi, e_mosi);
      chk("ss", ss, e_ss);
      for (int k = 0; k < NREQ; k++) begin
         if (gnt[k]) begin
            g_cyc.push_back(cyc);
            g_id.push_back(k);
         end
         if (done[k]) begin
            d_cyc.push_back(cyc);
            d_id.push_back(k);
            d_rd.push_back(rdata);
         end
      end
      if (sck && !sck_c) begin
         mosi_bits = {mosi_bits[6:0], mosi};
         n_rise++;
      end
      sck_c = sck;
      if (ss != '0) ss_hits++;
      ss_or = ss_or | ss;
      if (rst_n && !m_act && req != '0) begin
         fnd = 1'b0;
         for (int i = 1; i <= NREQ; i++) begin
            if (!fnd && req[(m_last+i)%NREQ]) begin
               fnd   = 1'b1;
               m_win = (m_last + i) % NREQ;
            end
         end
         m_act  = 1'b1;
         m_t0   = cyc;
         m_last = m_win;
         m_data = data[m_win*8 +: 8];
         m_slv  = int'(slv[m_win*SLVW +: SLVW]);
         if (mode == 1) m_rx = m_data;
         else if (mode == 2) m_rx = 8'h00;
         else m_rx = sl_byte;
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #2;
   endtask

   task automatic clr();
      g_cyc.delete();
      g_id.delete();
      d_cyc.delete();
      d_id.delete();
      d_rd.delete();
      n_rise = 0;
      ss_hits = 0;
      ss_or = '0;
   endtask

   task automatic xfer(input int k, input logic [1:0] s,
                       input logic [7:0] b, output int base);
      slv[k*SLVW +: SLVW] = s;
      data[k*8 +: 8] = b;
      req[k] = 1'b1;
      base = cyc;
      step(1);
      req[k] = 1'b0;
   endtask

   task automatic wait_n(input int which, input int n, input int budget);
      int k;
      k = 0;
      while (((which == 0) ? g_cyc.size() : d_cyc.size()) < n
             && k < budget) begin
         step(1);
         k++;
      end
      chk((which == 0) ? "gnt_wait" : "done_wait",
          (which == 0) ? g_cyc.size() : d_cyc.size(), n);
   endtask

   task automatic to_cycle(input int c);
      if (c > cyc) step(c - cyc);
   endtask

   logic [7:0] lb [3];

   initial begin
      int base;
      int n1;
      lb[0] = 8'h00;
      lb[1] = 8'hFF;
      lb[2] = 8'h81;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_ss", ss, 0);
      chk("rst_rdata", rdata, 0);
      step(3);
      rst_n = 1'b1;
      step(2);

      mode = 0;
      sl_byte = 8'h3C;
      clr();
      xfer(0, 2'd2, 8'hA5, base);
      wait_n(1, 1, 120);
      if (g_cyc.size() > 0) begin
         chk("t1_gnt_cyc", g_cyc[0] - base, 1);
         chk("t1_gnt_id", g_id[0], 0);
      end
      if (d_cyc.size() > 0) begin
         chk("t1_done_cyc", d_cyc[0] - base, 69);
         chk("t1_done_id", d_id[0], 0);
         chk("t1_rdata", d_rd[0], 8'h3C);
      end
      chk("t1_mosi_bits", mosi_bits, 8'hA5);
      chk("t1_rises", n_rise, 8);
      chk("t1_ss_cycles", ss_hits, 68);
      chk("t1_ss_val", ss_or, 3'b100);
      to_cycle(base + 73);

      clr();
      xfer(1, 2'd1, 8'h11, base);
      to_cycle(base + 30);
      rst_n = 1'b0;
      #1;
      chk("ar_sck", sck, 0);
      chk("ar_ss", ss, 0);
      chk("ar_mosi", mosi, 0);
      chk("ar_gnt", gnt, 0);
      chk("ar_done", done, 0);
      chk("ar_busy", busy, 0);
      chk("ar_rdata", rdata, 0);
      step(2);
      rst_n = 1'b1;
      chk("ar_no_done", d_cyc.size(), 0);

      sl_byte = 8'h96;
      clr();
      slv = {2'd1, 2'd0};
      data = {8'hC3, 8'h5A};
      req = 2'b11;
      base = cyc;
      wait_n(0, 4, 320);
      req = 2'b00;
      wait_n(1, 4, 120);
      for (int i = 0; i < 4; i++) begin
         if (g_cyc.size() > i) begin
            chk("ct_gnt_cyc", g_cyc[i] - base, 1 + 73*i);
            chk("ct_gnt_id", g_id[i], i % 2);
         end
         if (d_cyc.size() > i) begin
            chk("ct_done_cyc", d_cyc[i] - base, 69 + 73*i);
            chk("ct_done_id", d_id[i], i % 2);
            chk("ct_rdata", d_rd[i], 8'h96);
         end
      end
      to_cycle(base + 292);

      mode = 1;
      for (int t = 0; t < 3; t++) begin
         clr();
         xfer(0, 2'd0, lb[t], base);
         wait_n(1, 1, 120);
         if (d_rd.size() > 0) chk("lb_rdata", d_rd[0], lb[t]);
         to_cycle(base + 73);
      end

      mode = 2;
      clr();
      xfer(0, 2'd3, 8'h77, base);
      wait_n(1, 1, 120);
      if (d_cyc.size() > 0) begin
         chk("inv_done_cyc", d_cyc[0] - base, 69);
         chk("inv_rdata", d_rd[0], 8'h00);
      end
      chk("inv_ss_cycles", ss_hits, 0);
      to_cycle(base + 73);

      mode = 0;
      sl_byte = 8'h5A;
      clr();
      xfer(0, 2'd1, 8'hE7, base);
      to_cycle(base + 20);
      req[1] = 1'b1;
      step(1);
      req[1] = 1'b0;
      to_cycle(base + 95);
      n1 = 0;
      foreach (g_id[i]) if (g_id[i] == 1) n1++;
      chk("wd_no_gnt1", n1, 0);
      chk("wd_gnts", g_cyc.size(), 1);
      chk("wd_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
      $fatal(1);
   end

endmodule

// File: doc/spi_master_arb.md
# spi_master_arb

Shared SPI master that sequences 8-bit full-duplex transfers on the team's SPI bus (sck, mosi, miso, one-hot active-high ss) on behalf of NREQ local requesters. Requesters are served in round-robin order. Each transfer selects one slave, shifts one byte out MSB-first and captures one byte in. Timing margins are sized for slaves that pass sck and mosi through two-flop synchronisers and detect sck rising edges in their own clock domain.

## Interface
Parameters:
- NREQ, 2: number of requesters (≥2).
- NSS, 4: number of slave-select lines.
- SLVW, 2: width of each slave-index field; 2**SLVW ≥ NSS.
- CLKDIV, 4: sck half-period in Clk_i cycles (≥3).
- GAP, 4: cycles with all ss low between transfers (≥3).

Ports:
- Clk_i  in  1  system clock; everything is sampled on the rising edge.
- Rst_ni  in  1  reset; asynchronous, active-low.
- Req_i  in  NREQ  per-requester transfer request (level).
- Slv_i  in  NREQ*SLVW  target slave index; field k belongs to requester k.
- Data_i  in  NREQ*8  byte to transmit; field k belongs to requester k.
- Gnt_o  out  NREQ  one-cycle pulse: the request and data have been captured.
- Done_o  out  NREQ  one-cycle pulse: the transfer is complete and Rdata_o is valid.
- Rdata_o  out  8  last received byte; holds its value until the next Done_o.
- Busy_o  out  1  high in every state other than IDLE.
- sck_o  out  1  SPI clock, idles low (mode 0).
- mosi_o  out  1  serial data out, MSB first.
- miso_i  in  1  serial data in.
- ss_o  out  NSS  slave selects, active high, at most one high at a time.

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
- Reset values: all outputs 0. State IDLE. Round-robin pointer `last` = NREQ-1, so requester 0 wins first.
- IDLE: if any Req_i is high, pick the first requester with Req_i high, scanning from last+1 upward and wrapping modulo NREQ. At that clock edge:
  - capture its Data_i into the tx shift register and its Slv_i into the slave register;
  - set `last` to the winner;
  - go to SETUP.
- Requests that drop before being granted are ignored. Req_i is not re-examined until the next IDLE.
- SETUP: lasts CLKDIV cycles with sck_o=0, mosi_o=tx[7], and ss_o[slv]=1.
- HIGH: lasts CLKDIV cycles with sck_o=1.
- LOW: lasts CLKDIV cycles with sck_o=0. On entry, tx shifts left by one, so mosi_o shows the next bit.
- Bit sequence: SETUP→HIGH, then HIGH→LOW→HIGH, alternating for 8 HIGH phases in total. After the 8th HIGH, go to HOLD instead of LOW.
- miso sampling: on each clock edge that enters HIGH, rx ← {rx[6:0], miso_i}.
- HOLD: lasts CLKDIV cycles with sck_o=0, ss still asserted, and mosi_o held. This lets the slave's synchroniser register the last edge.
- HOLD exit edge: Rdata_o ← rx, ss_o ← 0, then enter GAP.
- GAP: lasts GAP cycles with all ss_o low and sck_o low, then return to IDLE.
- Invalid slave index (Slv ≥ NSS): the transfer runs with full timing but no ss_o bit is asserted. Rdata_o still loads whatever was sampled from miso_i.
- A down-counter of width ≥ clog2(max(CLKDIV,GAP)) times every phase. A 3-bit bit counter counts the HIGH phases.

## Timing
- Cycle 0 is the IDLE cycle in which the request is sampled.
- Gnt_o[k]=1 in cycle 1 only, which is the first SETUP cycle. Busy_o=1 from cycle 1 through the last GAP cycle.
- sck_o rises at the start of cycles 1+CLKDIV·(2i+1), for i = 0..7.
- Done_o[k]=1 and the new Rdata_o both appear in cycle 17·CLKDIV+1, which is the first GAP cycle.
- The block is back in IDLE in cycle 17·CLKDIV+GAP+1. The next grant pulse appears one cycle after that.
- With defaults: Gnt at cycle 1, Done at cycle 69, IDLE at cycle 73, next Gnt at cycle 74.
- mosi_o is stable ≥CLKDIV cycles before every sck_o rise. ss_o is stable ≥CLKDIV cycles before the first rise and after the last fall.
- Asynchronous reset mid-transfer: sck_o, ss_o, mosi_o, Gnt_o, Done_o, Busy_o and Rdata_o go to 0 immediately. No Done_o is issued for the aborted transfer.

## Test plan
- Single transfer: requester 0, Slv=2, Data=0xA5; slave model returns 0x3C on miso → Gnt_o[0] at cycle 1; ss_o=4'b0100 during cycles 1–68; mosi bits 1,0,1,0,0,1,0,1 observed at the sck rises; Done_o[0] at cycle 69 with Rdata_o=0x3C.
- Contention: Req_i=2'b11 held continuously → grants go 0, 1, 0, 1 at cycles 1, 74, 147, 220; each Done_o goes to the matching requester.
- Loopback: miso_i tied to mosi_o, Data=0x81, then 0xFF, then 0x00 → Rdata_o matches each sent byte.
- Reset at cycle 30 of a transfer → all outputs 0 that same cycle; no Done_o. After release, a new Req is granted 1 cycle after it is sampled, with requester 0 winning ties.
- Invalid index: Slv=3 with NSS=3 → ss_o stays 0 throughout; Done_o still at cycle 69; miso_i=0 gives Rdata_o=0x00.
- Request withdrawn: Req_i[1] pulses for one cycle while Busy_o=1 → no Gnt_o[1] is ever issued.
